// File: rtl/fifo_ctrl_ptr_if.sv
// Request/status bundle between a FIFO requester and the pointer controller.
// FIFO_PEAK_TRACK_EN adds the peak_occupancy signal.
interface fifo_ctrl_ptr_if #(
    parameter int unsigned PTR_L = 3
);
    logic             fifo_wr;
    logic             fifo_rd;
    logic             err_clr;
    logic [PTR_L-1:0] full_threshold;
    logic [PTR_L-1:0] empty_threshold;

    logic             mem_wr_en;
    logic             mem_rd_en;
    logic [PTR_L-2:0] wr_addr;
    logic [PTR_L-2:0] rd_addr;
    logic [PTR_L-1:0] occupancy;
    logic             fifo_full;
    logic             fifo_empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic             error;
`ifdef FIFO_PEAK_TRACK_EN
    logic [PTR_L-1:0] peak_occupancy;
`endif

    // Requester side
    modport master (
`ifdef FIFO_PEAK_TRACK_EN
        input  peak_occupancy,
`endif
        output fifo_wr, fifo_rd, err_clr, full_threshold, empty_threshold,
        input  mem_wr_en, mem_rd_en, wr_addr, rd_addr, occupancy,
        input  fifo_full, fifo_empty, almost_full, almost_empty,
        input  overflow, underflow, error
    );

    // Controller side
    modport slave (
`ifdef FIFO_PEAK_TRACK_EN
        output peak_occupancy,
`endif
        input  fifo_wr, fifo_rd, err_clr, full_threshold, empty_threshold,
        output mem_wr_en, mem_rd_en, wr_addr, rd_addr, occupancy,
        output fifo_full, fifo_empty, almost_full, almost_empty,
        output overflow, underflow, error
    );
endinterface

// File: rtl/fifo_ctrl_ptr.sv
// FIFO pointer/occupancy controller: accepts write/read requests, drives the
// memory strobes and addresses, and maintains status and sticky error flags.
// Optional macro FIFO_PEAK_TRACK_EN adds a peak-occupancy register.
module fifo_ctrl_ptr #(
    parameter int unsigned MEM_SIZE = 4,
    parameter int unsigned PTR_L    = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    fifo_ctrl_ptr_if.slave    bus_io
);
    localparam logic [PTR_L-1:0] FullCnt = PTR_L'(MEM_SIZE);

    logic [PTR_L-2:0] wr_addr_q, wr_addr_d;
    logic [PTR_L-2:0] rd_addr_q, rd_addr_d;
    logic [PTR_L-1:0] occ_q, occ_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic full, empty;
    logic wr_acc, rd_acc;
    logic wr_rej, rd_rej;

    assign full  = (occ_q == FullCnt);
    assign empty = (occ_q == '0);

    // Acceptance decode; requests seen during reset are dropped
    always_comb begin
        wr_acc = ~reset_i & bus_io.fifo_wr & (~full | bus_io.fifo_rd);
        rd_acc = ~reset_i & bus_io.fifo_rd & ~empty;
        wr_rej = bus_io.fifo_wr & full & ~bus_io.fifo_rd;
        rd_rej = bus_io.fifo_rd & empty;
    end

    // Next-state for pointers, count and sticky errors
    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        occ_d     = occ_q;
        if (wr_acc) wr_addr_d = wr_addr_q + 1'b1;
        if (rd_acc) rd_addr_d = rd_addr_q + 1'b1;
        if (wr_acc && !rd_acc) begin
            occ_d = occ_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            occ_d = occ_q - 1'b1;
        end
        // A new error in the clearing cycle keeps the flag set
        overflow_d  = wr_rej | (overflow_q & ~bus_io.err_clr);
        underflow_d = rd_rej | (underflow_q & ~bus_io.err_clr);
    end

    // State registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            occ_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            occ_q       <= occ_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef FIFO_PEAK_TRACK_EN
    logic [PTR_L-1:0] peak_q, peak_d;

    // Peak follows the post-edge count so it never lags occupancy
    always_comb begin
        peak_d = peak_q;
        if (bus_io.err_clr) begin
            peak_d = occ_d;
        end else if (occ_d > peak_q) begin
            peak_d = occ_d;
        end
    end

    // Peak register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign bus_io.peak_occupancy = peak_q;
`endif

    // Outputs; threshold flags are forced low while reset is held
    always_comb begin
        bus_io.mem_wr_en    = wr_acc;
        bus_io.mem_rd_en    = rd_acc;
        bus_io.wr_addr      = wr_addr_q;
        bus_io.rd_addr      = rd_addr_q;
        bus_io.occupancy    = occ_q;
        bus_io.fifo_full    = full;
        bus_io.fifo_empty   = empty;
        bus_io.almost_full  = ~reset_i & (occ_q >= bus_io.full_threshold);
        bus_io.almost_empty = ~reset_i & (occ_q <= bus_io.empty_threshold);
        bus_io.overflow     = overflow_q;
        bus_io.underflow    = underflow_q;
        bus_io.error        = overflow_q | underflow_q;
    end
endmodule

// File: tb/tb_fifo_ctrl_ptr.sv
// Scoreboard bench for fifo_ctrl_ptr: a driver issues requests and pushes the
// expected response from a count/pointer reference model; a monitor pops and
// compares each cycle.
module tb_fifo_ctrl_ptr;
    localparam int MEM = 4;
    localparam int PL  = 3;

    logic clk = 1'b0;
    logic reset;

    fifo_ctrl_ptr_if #(.PTR_L(PL)) bus ();

    fifo_ctrl_ptr #(.MEM_SIZE(MEM), .PTR_L(PL)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_io  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wr_en, rd_en, full, empty, afull, aempty;
        int occ, wa, ra, ovf, unf, peak;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_occ = 0, m_wa = 0, m_ra = 0, m_ovf = 0, m_unf = 0, m_peak = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_unf = 0; m_peak = 0;
    endtask

    task automatic step(input bit wr, input bit rd, input bit clr, input int fth, input int eth);
        exp_t e;
        int aw, ar;
        @(negedge clk);
        bus.fifo_wr         = wr;
        bus.fifo_rd         = rd;
        bus.err_clr         = clr;
        bus.full_threshold  = PL'(fth);
        bus.empty_threshold = PL'(eth);
        aw = (wr && (m_occ < MEM || rd)) ? 1 : 0;
        ar = (rd && m_occ > 0) ? 1 : 0;
        e.wr_en  = aw;
        e.rd_en  = ar;
        e.full   = (m_occ == MEM) ? 1 : 0;
        e.empty  = (m_occ == 0) ? 1 : 0;
        e.afull  = (m_occ >= fth) ? 1 : 0;
        e.aempty = (m_occ <= eth) ? 1 : 0;
        m_occ = m_occ + aw - ar;
        m_wa  = (m_wa + aw) % MEM;
        m_ra  = (m_ra + ar) % MEM;
        m_ovf = ((wr && !aw) || (m_ovf && !clr)) ? 1 : 0;
        m_unf = ((rd && !ar) || (m_unf && !clr)) ? 1 : 0;
        if (clr) m_peak = m_occ;
        else if (m_occ > m_peak) m_peak = m_occ;
        e.occ = m_occ; e.wa = m_wa; e.ra = m_ra;
        e.ovf = m_ovf; e.unf = m_unf; e.peak = m_peak;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.fifo_wr = 1'b0;
        bus.fifo_rd = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    // Monitor: strobes/flags before the edge, state after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mem_wr_en", bus.mem_wr_en, e.wr_en);
                chk("mem_rd_en", bus.mem_rd_en, e.rd_en);
                chk("fifo_full", bus.fifo_full, e.full);
                chk("fifo_empty", bus.fifo_empty, e.empty);
                chk("almost_full", bus.almost_full, e.afull);
                chk("almost_empty", bus.almost_empty, e.aempty);
                @(posedge clk);
                #1;
                chk("occupancy", bus.occupancy, e.occ);
                chk("wr_addr", bus.wr_addr, e.wa);
                chk("rd_addr", bus.rd_addr, e.ra);
                chk("overflow", bus.overflow, e.ovf);
                chk("underflow", bus.underflow, e.unf);
                chk("error", bus.error, e.ovf | e.unf);
`ifdef FIFO_PEAK_TRACK_EN
                chk("peak_occupancy", bus.peak_occupancy, e.peak);
`endif
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_occupancy"}, bus.occupancy, 0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_rd_addr"}, bus.rd_addr, 0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        chk({tag, "_underflow"}, bus.underflow, 0);
        chk({tag, "_mem_wr_en"}, bus.mem_wr_en, 0);
        chk({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_fifo_empty"}, bus.fifo_empty, 1);
        chk({tag, "_fifo_full"}, bus.fifo_full, 0);
        chk({tag, "_almost_full"}, bus.almost_full, 0);
        chk({tag, "_almost_empty"}, bus.almost_empty, 0);
        chk({tag, "_error"}, bus.error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pw;
        reset = 1'b1;
        bus.fifo_wr = 1'b0;
        bus.fifo_rd = 1'b0;
        bus.err_clr = 1'b0;
        bus.full_threshold  = 3'd3;
        bus.empty_threshold = 3'd1;
        #2;
        // Requests and low thresholds must not leak through while in reset
        bus.fifo_wr = 1'b1;
        bus.fifo_rd = 1'b1;
        bus.full_threshold = 3'd0;
        #1;
        chk_reset_state("rst");
        @(posedge clk);
        #1;
        chk_reset_state("rst_edge");
        @(negedge clk);
        reset = 1'b0;
        bus.fifo_wr = 1'b0;
        bus.fifo_rd = 1'b0;
        model_reset();

        // Fill, overflow, clear, simultaneous at full, drain, simultaneous at empty
        repeat (4) step(1, 0, 0, 3, 1);
        step(1, 0, 0, 3, 1);
        step(0, 0, 1, 3, 1);
        repeat (3) step(1, 1, 0, 3, 1);
        repeat (4) step(0, 1, 0, 3, 1);
        step(1, 1, 0, 3, 1);
        step(0, 0, 1, 3, 1);
        // Peak sequence: clear, write 3, read 2, clear
        step(0, 1, 0, 3, 1);
        step(0, 0, 1, 3, 1);
        repeat (3) step(1, 0, 0, 3, 1);
        repeat (2) step(0, 1, 0, 3, 1);
        step(0, 0, 1, 3, 1);

        // Randomised phases with varying write/read bias
        for (int ph = 0; ph < 8; ph++) begin
            pw = int'($urandom_range(15, 85));
            for (int i = 0; i < 40; i++) begin
                step(($urandom_range(0, 99) < pw),
                     ($urandom_range(0, 99) < (100 - pw)),
                     ($urandom_range(0, 99) < 6),
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)));
            end
        end

        // Drain, clear, load two entries, then reset between edges
        while (m_occ > 0) step(0, 1, 0, 3, 1);
        step(0, 0, 1, 3, 1);
        repeat (2) step(1, 0, 0, 3, 1);
        idle();
        repeat (3) @(posedge clk);
        chk("pre_reset_occupancy", bus.occupancy, 2);
        #2;
        reset = 1'b1;
        bus.fifo_wr = 1'b1;
        #1;
        chk_reset_state("async");
        @(posedge clk);
        #1;
        chk_reset_state("async_edge");
        @(negedge clk);
        reset = 1'b0;
        bus.fifo_wr = 1'b0;
        model_reset();

        // First request after reset is honoured
        step(1, 0, 0, 3, 1);
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 99) < 10), 3, 1);
        end
        idle();
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl_ptr.md
FIFO_CTRL_PTR -- requirements
Module: fifo_ctrl_ptr

Interface
REQ-001 Parameter MEM_SIZE, default 4: FIFO depth in entries; SHALL be a power of two, at least 2.
REQ-002 Parameter PTR_L, default 3: counter/threshold width, equal to log2(MEM_SIZE)+1; address width is PTR_L-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fifo_wr  input  1  write request.
REQ-006 fifo_rd  input  1  read request.
REQ-007 full_threshold  input  PTR_L  almost_full level.
REQ-008 empty_threshold  input  PTR_L  almost_empty level.
REQ-009 err_clr  input  1  synchronous clear of sticky error flags.
REQ-010 mem_wr_en  output  1  accepted write strobe to memory.
REQ-011 mem_rd_en  output  1  accepted read strobe to memory.
REQ-012 wr_addr  output  PTR_L-1  write pointer.
REQ-013 rd_addr  output  PTR_L-1  read pointer.
REQ-014 occupancy  output  PTR_L  stored entry count, 0..MEM_SIZE.
REQ-015 fifo_full, fifo_empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.
REQ-017 error  output  1  overflow OR underflow.

Function
REQ-018 Write accepted (mem_wr_en=1, combinational, same cycle) when fifo_wr and (not full, or full and fifo_rd).
REQ-019 Read accepted (mem_rd_en=1, combinational, same cycle) when fifo_rd and not empty.
REQ-020 On the clock edge, wr_addr increments by 1 per accepted write and rd_addr by 1 per accepted read; both wrap from MEM_SIZE-1 to 0.
REQ-021 occupancy: +1 for write only, -1 for read only, unchanged for both or neither; it never exceeds MEM_SIZE and never drops below 0.
REQ-022 Both requested while full: both accepted, occupancy stays MEM_SIZE, and both pointers advance.
REQ-023 Both requested while empty: write accepted, read rejected, underflow set, occupancy becomes 1.
REQ-024 fifo_full = (occupancy == MEM_SIZE); fifo_empty = (occupancy == 0); both are combinational from the registered count, so they reflect an access one cycle after its edge.
REQ-025 almost_full = (occupancy >= full_threshold); almost_empty = (occupancy <= empty_threshold); both combinational and threshold changes take effect immediately.
REQ-026 Rejected write (fifo_wr, full, no fifo_rd) sets overflow; rejected read (fifo_rd while empty) sets underflow; neither changes pointers or occupancy.
REQ-027 overflow and underflow stay set until an err_clr edge; if err_clr coincides with a new error, the new error wins and the flag stays 1.
REQ-028 Combinational outputs SHALL contain no latches; every always block assigns every output on every path.

Reset
REQ-029 While reset=1: wr_addr=0, rd_addr=0, occupancy=0, overflow=0, underflow=0, mem_wr_en=0, mem_rd_en=0.
REQ-030 While reset=1: fifo_empty=1, fifo_full=0, almost_full=0, almost_empty=0, error=0.
REQ-031 Reset asserted mid-operation clears state immediately without waiting for a clock; in-flight requests are discarded.
REQ-032 After deassertion, the first request is honoured on the next rising edge.

Configuration
REQ-033 Macro FIFO_PEAK_TRACK_EN defined: adds output peak_occupancy (PTR_L bits), a register holding the maximum occupancy since reset or err_clr.
REQ-034 peak_occupancy resets to 0 and updates on the same edge as occupancy; on err_clr it loads the current occupancy.
REQ-035 Macro FIFO_PEAK_TRACK_EN undefined: peak_occupancy port and its register are absent; all other behaviour is identical.

Verification (MEM_SIZE=4, PTR_L=3, full_threshold=3, empty_threshold=1)
REQ-036 Reset, then 4 single writes -> occupancy 1,2,3,4; almost_empty drops at 2, almost_full rises at 3; fifo_full=1 at 4; wr_addr wraps to 0.
REQ-037 Full, then fifo_wr alone -> mem_wr_en=0, overflow=1, error=1, occupancy stays 4; err_clr pulse -> overflow=0.
REQ-038 Full, then fifo_wr+fifo_rd for 3 cycles -> both strobes high each cycle, occupancy stays 4, both pointers advance by 3 mod 4.
REQ-039 Empty, then fifo_wr+fifo_rd -> mem_wr_en=1, mem_rd_en=0, underflow=1, occupancy=1, fifo_empty=0 next cycle.
REQ-040 Occupancy 2, assert reset between edges -> occupancy, pointers and flags clear immediately; fifo_empty=1.
REQ-041 With FIFO_PEAK_TRACK_EN: write 3, read 2 -> peak_occupancy=3; err_clr -> peak_occupancy=1.
